shared_clause_ring: RTL and testbench

Second-generation shared clause exchange for the SatSwarmV2 Mega tile. NUM_CORES solver cores push learned-clause packets through a round-robin arbiter into a circular RAM. A registered broadcast port drains the RAM to all cores, with ready backpressure, origin tagging and a run-time selectable overflow policy. Sits between the per-core learnt-clause exporters and the broadcast fan-out network.

---
 rtl/satswarmv2_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/shared_clause_ring.sv | 117 +++++++++++
 tb/tb_shared_clause_ring.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/satswarmv2_pkg.sv
// Shared types for the SatSwarmV2 clause-exchange fabric.
// Holds the packet format, the ring entry layout and small helpers.
`timescale 1ns/1ps
package satswarmv2_pkg;

    localparam int SCR_DROP_CNT_W = 32;
    localparam int SCR_SRC_W_MAX  = 8;

    typedef struct packed {
        logic [7:0]  lbd;
        logic [23:0] lits;
    } shared_packet_t;

    typedef struct packed {
        shared_packet_t             pkt;
        logic [SCR_SRC_W_MAX-1:0]   src;
    } scr_entry_t;

    function automatic logic [SCR_DROP_CNT_W-1:0] sat_inc(
        input logic [SCR_DROP_CNT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after rr_ptr wins;
// rr_ptr advances past the winner on every accepted grant.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int SRC_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] req,
    input  logic                 enable,
    output logic [NUM_CORES-1:0] grant,
    output logic [SRC_W-1:0]     grant_idx,
    output logic                 any_grant
);

    logic [SRC_W-1:0] rr_q, rr_d;
    logic [SRC_W:0]   cand;
    logic             hit;
    logic [SRC_W-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = {1'b0, rr_q} + (SRC_W+1)'(i);
            if (cand >= (SRC_W+1)'(NUM_CORES))
                cand = cand - (SRC_W+1)'(NUM_CORES);
            if (!hit && req[cand[SRC_W-1:0]]) begin
                hit = 1'b1;
                idx = cand[SRC_W-1:0];
            end
        end
    end

    // Grant is suppressed while reset is asserted, not just after it.
    assign any_grant = hit && enable && !rst;
    assign grant_idx = idx;
    assign grant     = any_grant ? (NUM_CORES'(1) << idx) : '0;

    always_comb begin
        rr_d = rr_q;
        if (any_grant)
            rr_d = (idx == SRC_W'(NUM_CORES - 1)) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end

endmodule

// File: rtl/shared_clause_ring.sv
// Multi-writer circular clause RAM with registered broadcast port.
// Define SCB_SELF_FILTER_EN to add bcast_core_mask (origin self-filter).
`timescale 1ns/1ps
module shared_clause_ring
    import satswarmv2_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int DEPTH     = 4096,
    parameter int PTR_W     = $clog2(DEPTH),
    parameter int SRC_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            overwrite_mode,
    input  logic [NUM_CORES-1:0]            write_req,
    input  shared_packet_t [NUM_CORES-1:0]  write_payload,
    output logic [NUM_CORES-1:0]            write_grant,
    output logic                            bcast_valid,
    input  logic                            bcast_ready,
    output shared_packet_t                  bcast_payload,
    output logic [SRC_W-1:0]                bcast_src,
    output logic [PTR_W:0]                  count,
    output logic                            full,
    output logic                            empty,
    output logic [SCR_DROP_CNT_W-1:0]       drop_count
`ifdef SCB_SELF_FILTER_EN
    ,
    output logic [NUM_CORES-1:0]            bcast_core_mask
`endif
);

    scr_entry_t                 mem [DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]             count_q, count_d;
    logic [SCR_DROP_CNT_W-1:0]  drop_q, drop_d;
    logic                       bvalid_q;
    shared_packet_t             bpay_q;
    logic [SRC_W-1:0]           bsrc_q;

    logic                       wr, rd, ovf, drop_evt;
    logic [SRC_W-1:0]           gidx;
    scr_entry_t                 wr_entry;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

    rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .SRC_W     (SRC_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (write_req),
        .enable    (!full || overwrite_mode),
        .grant     (write_grant),
        .grant_idx (gidx),
        .any_grant (wr)
    );

    assign wr_entry.pkt = write_payload[gidx];
    assign wr_entry.src = SCR_SRC_W_MAX'(gidx);

    always_comb begin
        rd       = !empty && (!bvalid_q || bcast_ready);
        // Full write with no read: oldest entry is sacrificed.
        ovf      = wr && full && !rd;
        drop_evt = ovf || (!overwrite_mode && full && |write_req);
        wr_ptr_d = wr_ptr_q + PTR_W'(wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd || ovf);
        count_d  = count_q;
        if (wr && !rd && !ovf)
            count_d = count_q + 1'b1;
        else if (rd && !wr)
            count_d = count_q - 1'b1;
        drop_d   = drop_evt ? sat_inc(drop_q) : drop_q;
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            bvalid_q <= 1'b0;
            bpay_q   <= '0;
            bsrc_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            if (rd) begin
                bpay_q   <= mem[rd_ptr_q].pkt;
                bsrc_q   <= mem[rd_ptr_q].src[SRC_W-1:0];
                bvalid_q <= 1'b1;
            end else if (bcast_ready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    assign bcast_valid   = bvalid_q;
    assign bcast_payload = bpay_q;
    assign bcast_src     = bsrc_q;
    assign count         = count_q;
    assign drop_count    = drop_q;

`ifdef SCB_SELF_FILTER_EN
    assign bcast_core_mask = bvalid_q ? ~(NUM_CORES'(1) << bsrc_q) : '0;
`endif

endmodule

// File: tb/tb_shared_clause_ring.sv
// Randomized scoreboard bench for shared_clause_ring (4 cores, DEPTH 4).
// Reference: RAM as a FIFO queue plus one output slot, rule-level updates.
`timescale 1ns/1ps
module tb_shared_clause_ring;
    import satswarmv2_pkg::*;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int SW = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   overwrite_mode = 1'b0;
    logic [N-1:0]           write_req = '0;
    shared_packet_t [N-1:0] write_payload = '0;
    logic [N-1:0]           write_grant;
    logic                   bcast_valid;
    logic                   bcast_ready = 1'b0;
    shared_packet_t         bcast_payload;
    logic [SW-1:0]          bcast_src;
    logic [$clog2(D):0]     count;
    logic                   full;
    logic                   empty;
    logic [31:0]            drop_count;
`ifdef SCB_SELF_FILTER_EN
    logic [N-1:0]           bcast_core_mask;
`endif

    shared_clause_ring #(
        .NUM_CORES (N),
        .DEPTH     (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .overwrite_mode (overwrite_mode),
        .write_req      (write_req),
        .write_payload  (write_payload),
        .write_grant    (write_grant),
        .bcast_valid    (bcast_valid),
        .bcast_ready    (bcast_ready),
        .bcast_payload  (bcast_payload),
        .bcast_src      (bcast_src),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .drop_count     (drop_count)
`ifdef SCB_SELF_FILTER_EN
        ,
        .bcast_core_mask(bcast_core_mask)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p;
        int          s;
    } ent_t;

    int          n_cmp = 0;
    int          n_bad = 0;

    ent_t        mq[$];
    ent_t        expq[$];
    logic [31:0] delivered[$];
    int          m_rr = 0;
    bit          m_ov = 0;
    ent_t        m_oreg;
    logic [31:0] m_drop = 0;
    int          last_gi = -1;

    logic [N-1:0] d_req = '0;
    logic [31:0]  d_pay [N];
    bit           d_mode = 0;
    bit           d_ready = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        int          gi;
        bit          mfull, mempty, load;
        logic [N-1:0] eg;
        ent_t        e;
        @(negedge clk);
        for (int i = 0; i < N; i++) write_payload[i] = shared_packet_t'(d_pay[i]);
        write_req      = d_req;
        overwrite_mode = d_mode;
        bcast_ready    = d_ready;
        #1;
        mfull  = (mq.size() == D);
        mempty = (mq.size() == 0);
        gi = -1;
        for (int i = 0; i < N; i++)
            if (gi < 0 && d_req[(m_rr + i) % N]) gi = (m_rr + i) % N;
        if (gi >= 0 && mfull && !d_mode) gi = -1;
        eg = (gi >= 0) ? (N'(1) << gi) : '0;
        chk("grant", 32'(write_grant), 32'(eg));
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mfull));
        chk("empty", 32'(empty), 32'(mempty));
        chk("drop_count", drop_count, m_drop);
        chk("bvalid", 32'(bcast_valid), 32'(m_ov));
        if (m_ov) begin
            chk("bpayload", 32'(bcast_payload), m_oreg.p);
            chk("bsrc", 32'(bcast_src), 32'(m_oreg.s));
`ifdef SCB_SELF_FILTER_EN
            chk("bmask", 32'(bcast_core_mask), 32'(~(N'(1) << m_oreg.s)));
`endif
        end
        load = !mempty && (!m_ov || d_ready);
        if (load) begin
            e = mq.pop_front();
            m_ov = 1;
            m_oreg = e;
            expq.push_back(e);
        end else if (d_ready) begin
            m_ov = 0;
        end
        if (gi >= 0) begin
            if (mfull && !load) begin
                e = mq.pop_front();
                if (m_drop != 32'hFFFF_FFFF) m_drop++;
            end
            e.p = d_pay[gi];
            e.s = gi;
            mq.push_back(e);
            m_rr = (gi + 1) % N;
            d_req[gi] = 1'b0;
        end
        if (!d_mode && mfull && d_req != '0 && gi < 0)
            if (m_drop != 32'hFFFF_FFFF) m_drop++;
        last_gi = gi;
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_grant"}, 32'(write_grant), 32'h0);
        chk({tag, "_bvalid"}, 32'(bcast_valid), 32'h0);
        chk({tag, "_bpayload"}, 32'(bcast_payload), 32'h0);
        chk({tag, "_bsrc"}, 32'(bcast_src), 32'h0);
        chk({tag, "_count"}, 32'(count), 32'h0);
        chk({tag, "_empty"}, 32'(empty), 32'h1);
        chk({tag, "_full"}, 32'(full), 32'h0);
        chk({tag, "_drop"}, drop_count, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #3 rst = 1'b1;
        #1 rst_checks(tag);
        d_req = '0;
        write_req = '0;
        mq.delete();
        expq.delete();
        delivered.delete();
        m_rr = 0;
        m_ov = 0;
        m_drop = 0;
        @(negedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bcast_valid && bcast_ready) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL mon_unexpected: got %0h required nothing",
                             32'(bcast_payload));
                end else begin
                    e = expq.pop_front();
                    chk("mon_payload", 32'(bcast_payload), e.p);
                    chk("mon_src", 32'(bcast_src), 32'(e.s));
                    delivered.push_back(32'(bcast_payload));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1);
    end

    initial begin : stim
        int pk;
        int iss;
        for (int i = 0; i < N; i++) d_pay[i] = '0;
        #1 rst_checks("por");
        #13 rst = 1'b0;

        // single packet from core 2
        d_ready = 1;
        d_req[2] = 1'b1;
        d_pay[2] = 32'hA5;
        tick();
        for (int k = 0; k < 5; k++) tick();
        chk("single_n", 32'(delivered.size()), 32'd1);
        if (delivered.size() > 0) chk("single_pkt", delivered[0], 32'hA5);

        // all cores requesting continuously
        do_reset("rst1");
        d_ready = 1;
        for (int k = 0; k < 12; k++) begin
            for (int c = 0; c < N; c++)
                if (!d_req[c]) begin
                    d_req[c] = 1'b1;
                    d_pay[c] = $urandom;
                end
            tick();
            chk("rr_order", 32'(last_gi), 32'(k % N));
        end
        d_req = '0;
        for (int k = 0; k < 6; k++) tick();

        // drop-newest with stalled output
        do_reset("rst2");
        d_mode = 0;
        d_ready = 0;
        pk = 0;
        for (int k = 0; k < 10; k++) begin
            if (!d_req[0] && pk < 7) begin
                d_req[0] = 1'b1;
                d_pay[0] = 32'h40 + pk;
                pk++;
            end
            tick();
        end
        d_req = '0;
        d_ready = 1;
        for (int k = 0; k < 8; k++) tick();

        // overwrite-oldest with stalled output
        do_reset("rst3");
        d_mode = 1;
        d_ready = 0;
        for (int k = 1; k <= 8; k++) begin
            d_req[0] = 1'b1;
            d_pay[0] = k;
            tick();
        end
        d_req = '0;
        tick();
        tick();
        d_ready = 1;
        for (int k = 0; k < 8; k++) tick();
        chk("ow_drop", drop_count, 32'd3);
        chk("ow_n", 32'(delivered.size()), 32'd5);
        if (delivered.size() == 5) begin
            chk("ow_0", delivered[0], 32'd1);
            for (int k = 1; k < 5; k++) chk("ow_k", delivered[k], 32'(k + 4));
        end

        // pointer wrap, ready toggling
        do_reset("rst4");
        d_mode = 0;
        iss = 0;
        for (int k = 0; k < 80; k++) begin
            if (iss == 10 && !d_req[1]) break;
            if (!d_req[1] && iss < 10) begin
                d_req[1] = 1'b1;
                d_pay[1] = 32'd100 + iss;
                iss++;
            end
            d_ready = (k % 2) == 0;
            tick();
        end
        d_ready = 1;
        for (int k = 0; k < 10; k++) tick();
        chk("wrap_n", 32'(delivered.size()), 32'd10);
        if (delivered.size() == 10)
            for (int k = 0; k < 10; k++) chk("wrap_k", delivered[k], 32'(100 + k));

        // randomized traffic
        do_reset("rst5");
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < N; c++)
                if (!d_req[c] && $urandom_range(0, 2) == 0) begin
                    d_req[c] = 1'b1;
                    d_pay[c] = $urandom;
                end
            d_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) d_mode = ~d_mode;
            tick();
        end
        d_req = '0;
        d_ready = 1;
        for (int k = 0; k < 10; k++) tick();

        // async reset with occupancy 3
        do_reset("rst6");
        d_mode = 0;
        d_ready = 0;
        for (int k = 0; k < 4; k++) begin
            d_req[3] = 1'b1;
            d_pay[3] = k + 1;
            tick();
        end
        tick();
        chk("pre_rst_count", 32'(count), 32'd3);
        do_reset("rst7");
        d_ready = 1;
        for (int k = 0; k < 4; k++) tick();
        d_req[2] = 1'b1;
        d_pay[2] = 32'h5A;
        tick();
        for (int k = 0; k < 4; k++) tick();
        chk("post_rst_n", 32'(delivered.size()), 32'd1);
        chk("exp_drained", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
